// File: rtl/axi_stride_read_master_pkg.sv
// axi_stride_read_master_pkg: shared FSM state type, errorCode bit indices and AXI burst/size constants
package axi_stride_read_master_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_GAP, ST_DRAIN} state_t;
  localparam int ERR_ID = 0;
  localparam int ERR_LAST = 1;
  localparam int ERR_UNEXP = 2;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1B = 3'b000;
endpackage

// File: rtl/axi_stride_read_master_if.sv
// axi_stride_read_master_if: AXI read address/data channels; master drives ar_valid/ar_addr/ar_len/ar_id/r_ready, slave drives ar_ready/r_valid/r_data/r_last/r_id
interface axi_stride_read_master_if #(
  parameter int ADDR_BITS = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic ar_valid;
  logic ar_ready;
  logic [ADDR_BITS-1:0] ar_addr;
  logic [BURST_LEN_WIDTH-1:0] ar_len;
  logic [TID_WIDTH-1:0] ar_id;
  logic r_valid;
  logic r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic r_last;
  logic [TID_WIDTH-1:0] r_id;
  modport master (output ar_valid, ar_addr, ar_len, ar_id, r_ready, input ar_ready, r_valid, r_data, r_last, r_id);
  modport slave (input ar_valid, ar_addr, ar_len, ar_id, r_ready, output ar_ready, r_valid, r_data, r_last, r_id);
endinterface

// File: rtl/axi_stride_read_master_tracker.sv
// axi_stride_read_master_tracker: outstanding-burst and beat counters, R beat capture, sticky R protocol error flags (clk/rst, clear, ar_hs/r_hs + R payload in; outstanding, beat_valid/beat_data, error_code out)
module axi_stride_read_master_tracker
  import axi_stride_read_master_pkg::*;
#(
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LOG_MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ar_hs,
  input  logic r_hs,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic r_last,
  input  logic [TID_WIDTH-1:0] r_id,
  input  logic [TID_WIDTH-1:0] exp_id,
  input  logic [BURST_LEN_WIDTH-1:0] exp_len,
  output logic [LOG_MAX_OUTSTANDING:0] outstanding,
  output logic beat_valid,
  output logic [DATA_WIDTH-1:0] beat_data,
  output logic [2:0] error_code
);
  localparam int OW = LOG_MAX_OUTSTANDING + 1;
  logic ok_beat;
  logic last_hs;
  logic [2:0] err_set;
  logic [BURST_LEN_WIDTH-1:0] beat_cnt;
  assign ok_beat = r_hs && outstanding != '0;
  assign last_hs = ok_beat && r_last;
  always_comb begin
    err_set = '0;
    err_set[ERR_ID] = ok_beat && r_id != exp_id;
    err_set[ERR_LAST] = ok_beat && (r_last != (beat_cnt == exp_len));
    err_set[ERR_UNEXP] = r_hs && outstanding == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      beat_cnt <= '0;
      beat_valid <= 1'b0;
      beat_data <= '0;
      error_code <= '0;
    end else begin
      beat_valid <= ok_beat;
      if (ok_beat) beat_data <= r_data;
      outstanding <= outstanding + OW'(ar_hs) - OW'(last_hs);
      if (clear) beat_cnt <= '0;
      else if (ok_beat) beat_cnt <= r_last ? '0 : beat_cnt + BURST_LEN_WIDTH'(1);
      error_code <= clear ? '0 : error_code | err_set;
    end
  end
endmodule

// File: rtl/axi_stride_read_master.sv
// axi_stride_read_master: strided AXI read-burst initiator (clk/rst, start + cfg_* in; AXI AR/R via interface m; beat_valid/beat_data, busy, done, errorCode out)
module axi_stride_read_master
  import axi_stride_read_master_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LOG_MAX_OUTSTANDING = 2,
  parameter int REQ_CNT_WIDTH = 8,
  parameter int GAP_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_BITS-1:0] cfg_base_addr,
  input  logic [ADDR_BITS-1:0] cfg_stride,
  input  logic [REQ_CNT_WIDTH-1:0] cfg_req_num,
  input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
  input  logic [TID_WIDTH-1:0] cfg_id,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  axi_stride_read_master_if.master m,
  output logic beat_valid,
  output logic [DATA_WIDTH-1:0] beat_data,
  output logic busy,
  output logic done,
  output logic [2:0] errorCode
);
  localparam int OW = LOG_MAX_OUTSTANDING + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(2 ** LOG_MAX_OUTSTANDING);
  state_t state, next_state;
  logic [ADDR_BITS-1:0] addr_reg, stride_r;
  logic [REQ_CNT_WIDTH-1:0] req_num_r, issued;
  logic [BURST_LEN_WIDTH-1:0] len_r;
  logic [TID_WIDTH-1:0] id_r;
  logic [GAP_WIDTH-1:0] gap_r, gap_cnt;
  logic [OW-1:0] outstanding;
  logic accept, ar_hs;
  assign accept = state == ST_IDLE && start;
  assign ar_hs = m.ar_valid && m.ar_ready;
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: next_state = (start && cfg_req_num != '0) ? ST_ADDR : ST_IDLE;
      ST_ADDR: if (ar_hs) next_state = (issued + REQ_CNT_WIDTH'(1) == req_num_r) ? ST_DRAIN : (gap_r != '0 ? ST_GAP : ST_ADDR);
      ST_GAP: next_state = gap_cnt == GAP_WIDTH'(1) ? ST_ADDR : ST_GAP;
      ST_DRAIN: next_state = outstanding == '0 ? ST_IDLE : ST_DRAIN;
      default: next_state = ST_IDLE;
    endcase
  end
  always_comb begin
    busy = state != ST_IDLE;
    m.ar_valid = state == ST_ADDR && outstanding < MAX_OUT;
    m.ar_addr = addr_reg;
    m.ar_len = len_r;
    m.ar_id = id_r;
    m.r_ready = busy || outstanding != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      stride_r <= '0;
      req_num_r <= '0;
      len_r <= '0;
      id_r <= '0;
      gap_r <= '0;
      issued <= '0;
      gap_cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= (accept && cfg_req_num == '0) || (state == ST_DRAIN && outstanding == '0);
      if (accept) begin
        addr_reg <= cfg_base_addr;
        stride_r <= cfg_stride;
        req_num_r <= cfg_req_num;
        len_r <= cfg_len;
        id_r <= cfg_id;
        gap_r <= cfg_gap;
        issued <= '0;
      end
      if (ar_hs) begin
        addr_reg <= addr_reg + stride_r;
        issued <= issued + REQ_CNT_WIDTH'(1);
        gap_cnt <= gap_r;
      end else if (state == ST_GAP) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
    end
  end
  axi_stride_read_master_tracker #(
    .BURST_LEN_WIDTH(BURST_LEN_WIDTH),
    .TID_WIDTH(TID_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LOG_MAX_OUTSTANDING(LOG_MAX_OUTSTANDING)
  ) u_trk (
    .clk(clk),
    .rst(rst),
    .clear(accept),
    .ar_hs(ar_hs),
    .r_hs(m.r_valid && m.r_ready),
    .r_data(m.r_data),
    .r_last(m.r_last),
    .r_id(m.r_id),
    .exp_id(id_r),
    .exp_len(len_r),
    .outstanding(outstanding),
    .beat_valid(beat_valid),
    .beat_data(beat_data),
    .error_code(errorCode)
  );
endmodule

// File: tb/tb_axi_stride_read_master.sv
// tb_axi_stride_read_master: directed + randomized runs against a RAM responder and an arithmetic reference model
module tb_axi_stride_read_master;
  typedef struct {
    int cyc;
    logic [15:0] addr;
    logic [7:0] len;
    logic [7:0] id;
  } ar_t;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [15:0] cfg_base_addr = 0, cfg_stride = 0;
  logic [7:0] cfg_req_num = 0, cfg_len = 0, cfg_id = 0;
  logic [3:0] cfg_gap = 0;
  logic beat_valid, busy, done;
  logic [7:0] beat_data;
  logic [2:0] error_code;
  logic [7:0] mem [65536];
  ar_t ar_log[$], arq[$];
  logic [7:0] beat_log[$];
  bit rlast_log[$];
  int valid_cyc[$];
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0, first_r_cyc = -1;
  bit ar_rdy_en = 1, ar_rdy_rand = 0;
  int r_stall = 0, early_last = -1, inj_req = 0;
  logic [7:0] rid_xor = 0;
  axi_stride_read_master_if bus();
  axi_stride_read_master dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride), .cfg_req_num(cfg_req_num),
    .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_gap(cfg_gap),
    .m(bus),
    .beat_valid(beat_valid), .beat_data(beat_data), .busy(busy), .done(done), .errorCode(error_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // AXI RAM responder and channel monitor: sample at negedge, drive at posedge+1
  initial begin
    ar_t a, cur;
    bit active, inj_active, r_hs, prev_stall;
    int beat_i, wait_c, inj_done;
    logic [15:0] prev_addr;
    active = 0; inj_active = 0; r_hs = 0; prev_stall = 0; beat_i = 0; wait_c = 0; inj_done = 0; prev_addr = 0;
    bus.ar_ready = 0; bus.r_valid = 0; bus.r_data = 0; bus.r_last = 0; bus.r_id = 0;
    forever begin
      @(negedge clk);
      if (prev_stall && !rst) chk("ar_stable", {15'd0, bus.ar_valid, bus.ar_addr}, {15'd0, 1'b1, prev_addr});
      prev_stall = bus.ar_valid && !bus.ar_ready;
      prev_addr = bus.ar_addr;
      if (bus.ar_valid) valid_cyc.push_back(cyc);
      if (bus.ar_valid && bus.ar_ready) begin
        a = '{cyc, bus.ar_addr, bus.ar_len, bus.ar_id};
        ar_log.push_back(a);
        arq.push_back(a);
      end
      r_hs = bus.r_valid && bus.r_ready;
      if (r_hs) begin
        rlast_log.push_back(bus.r_last);
        if (first_r_cyc < 0) first_r_cyc = cyc;
      end
      if (beat_valid) beat_log.push_back(beat_data);
      if (done) done_cnt++;
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        arq.delete();
        active = 0;
        inj_active = 0;
      end else if (r_hs) begin
        if (inj_active) inj_active = 0;
        else if (bus.r_last) active = 0;
        else beat_i++;
      end
      bus.ar_ready = ar_rdy_rand ? 1'($urandom % 2) : ar_rdy_en;
      if (!active && !inj_active && arq.size() > 0) begin
        cur = arq.pop_front();
        active = 1;
        beat_i = 0;
        wait_c = r_stall;
      end
      if (!active && !inj_active && inj_req > inj_done) begin
        inj_active = 1;
        inj_done++;
      end
      if (active && wait_c > 0) begin
        wait_c--;
        bus.r_valid = 0;
        bus.r_last = 0;
      end else if (active) begin
        bus.r_valid = 1;
        bus.r_data = mem[cur.addr + 16'(beat_i)];
        bus.r_id = cur.id ^ rid_xor;
        bus.r_last = (early_last >= 0) ? beat_i == early_last : beat_i == int'(cur.len);
      end else if (inj_active) begin
        bus.r_valid = 1;
        bus.r_data = 8'h5a;
        bus.r_id = 8'd5;
        bus.r_last = 1;
      end else begin
        bus.r_valid = 0;
        bus.r_last = 0;
      end
    end
  end
  task automatic clear_logs();
    ar_log.delete();
    beat_log.delete();
    rlast_log.delete();
    valid_cyc.delete();
    done_cnt = 0;
    first_r_cyc = -1;
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 1);
    @(negedge clk);
  endtask
  task automatic run(input logic [15:0] base, input logic [15:0] stride, input logic [7:0] num,
                     input logic [7:0] len, input logic [7:0] id, input logic [3:0] gap,
                     input logic [2:0] exp_err, input int bpb);
    logic [15:0] a;
    int bi = 0;
    cfg_base_addr = base; cfg_stride = stride; cfg_req_num = num; cfg_len = len; cfg_id = id; cfg_gap = gap;
    clear_logs();
    pulse_start();
    chk("err_cleared", {29'd0, error_code}, 0);
    chk("busy_run", {31'd0, busy}, 1);
    cfg_base_addr = 16'($urandom); cfg_stride = 16'($urandom); cfg_req_num = 8'($urandom);
    cfg_len = 8'($urandom); cfg_id = 8'($urandom); cfg_gap = 4'($urandom);
    wait_done();
    chk("ar_count", ar_log.size(), num);
    for (int i = 0; i < int'(num); i++) begin
      a = base + 16'(i) * stride;
      if (i < ar_log.size()) begin
        chk("ar_addr", {16'd0, ar_log[i].addr}, {16'd0, a});
        chk("ar_len", {24'd0, ar_log[i].len}, {24'd0, len});
        chk("ar_id", {24'd0, ar_log[i].id}, {24'd0, id});
      end
      for (int k = 0; k < bpb; k++) begin
        if (bi < beat_log.size()) chk("beat_data", {24'd0, beat_log[bi]}, {24'd0, mem[a + 16'(k)]});
        bi++;
      end
    end
    chk("beat_count", beat_log.size(), bi);
    chk("done_once", done_cnt, 1);
    chk("error_code", {29'd0, error_code}, {29'd0, exp_err});
    chk("busy_end", {31'd0, busy}, 0);
  endtask
  initial begin
    int n;
    logic [7:0] num, len;
    foreach (mem[i]) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ar_valid", {31'd0, bus.ar_valid}, 0);
    chk("rst_r_ready", {31'd0, bus.r_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_beat_valid", {31'd0, beat_valid}, 0);
    chk("rst_error", {29'd0, error_code}, 0);
    chk("rst_ar_addr", {16'd0, bus.ar_addr}, 0);
    // back-to-back increasing reads, RAM preloaded 0..3
    for (int i = 0; i < 4; i++) mem[16'h0eef + 16'(i)] = 8'(i);
    run(16'h0eef, 16'h0001, 4, 0, 3, 0, 3'b000, 1);
    for (int i = 0; i < 4 && i < ar_log.size(); i++) chk("b2b_cycle", ar_log[i].cyc - ar_log[0].cyc, i);
    for (int i = 0; i < 4 && i < beat_log.size(); i++) chk("b2b_data", {24'd0, beat_log[i]}, i);
    // outstanding limit with a slow responder
    r_stall = 20;
    run(16'h1000, 16'h0010, 8, 0, 1, 0, 3'b000, 1);
    r_stall = 0;
    n = 0;
    foreach (ar_log[i]) if (ar_log[i].cyc < first_r_cyc) n++;
    chk("ar_before_first_r", n, 4);
    n = 0;
    if (ar_log.size() >= 4) foreach (valid_cyc[i]) if (valid_cyc[i] > ar_log[3].cyc && valid_cyc[i] <= first_r_cyc) n++;
    chk("ar_valid_held_low", n, 0);
    // negative stride with address wrap
    len = 8'($urandom_range(0, 3));
    run(16'h0001, 16'hfffe, 3, len, 8'h21, 4'($urandom_range(0, 2)), 3'b000, int'(len) + 1);
    if (ar_log.size() == 3) begin
      chk("wrap_addr0", {16'd0, ar_log[0].addr}, 32'h0001);
      chk("wrap_addr1", {16'd0, ar_log[1].addr}, 32'hffff);
      chk("wrap_addr2", {16'd0, ar_log[2].addr}, 32'hfffd);
    end
    // multi-beat bursts separated by a gap
    run(16'h2000, 16'h0040, 2, 2, 7, 3, 3'b000, 3);
    if (ar_log.size() == 2) chk("gap_spacing", ar_log[1].cyc - ar_log[0].cyc, 4);
    chk("r_beats", rlast_log.size(), 6);
    if (rlast_log.size() == 6) begin
      chk("last_beat3", {31'd0, rlast_log[2]}, 1);
      chk("last_beat6", {31'd0, rlast_log[5]}, 1);
      chk("notlast_beat1", {31'd0, rlast_log[0]}, 0);
    end
    // randomized runs with random AR backpressure
    ar_rdy_rand = 1;
    for (int t = 0; t < 5; t++) begin
      num = 8'($urandom_range(1, 6));
      len = 8'($urandom_range(0, 3));
      r_stall = $urandom_range(0, 3);
      run(16'($urandom), 16'($urandom), num, len, 8'($urandom), 4'($urandom_range(0, 2)), 3'b000, int'(len) + 1);
    end
    ar_rdy_rand = 0;
    r_stall = 0;
    // R id mismatch
    rid_xor = 8'h01;
    run(16'h3000, 16'h0001, 1, 0, 5, 0, 3'b001, 1);
    rid_xor = 0;
    // early last on a 3-beat burst; previous id error is cleared by this start
    early_last = 1;
    run(16'h3100, 16'h0004, 1, 2, 5, 0, 3'b010, 2);
    early_last = -1;
    // unsolicited beat while busy with nothing outstanding
    ar_rdy_en = 0;
    cfg_base_addr = 16'h3200; cfg_stride = 1; cfg_req_num = 1; cfg_len = 0; cfg_id = 5; cfg_gap = 0;
    clear_logs();
    pulse_start();
    inj_req++;
    repeat (6) @(negedge clk);
    chk("unexp_flag", {29'd0, error_code}, 32'b100);
    chk("unexp_dropped", beat_log.size(), 0);
    ar_rdy_en = 1;
    wait_done();
    chk("unexp_sticky", {29'd0, error_code}, 32'b100);
    chk("unexp_beats", beat_log.size(), 1);
    run(16'h3300, 16'h0002, 2, 1, 9, 1, 3'b000, 2);
    // zero-length run
    cfg_req_num = 0;
    clear_logs();
    pulse_start();
    chk("zero_done", {31'd0, done}, 1);
    chk("zero_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 chk("zero_done_pulse", {31'd0, done}, 0);
    repeat (4) @(negedge clk);
    chk("zero_no_ar", ar_log.size(), 0);
    // reset in the middle of a run
    cfg_base_addr = 16'h4000; cfg_stride = 16'h0008; cfg_req_num = 8; cfg_len = 3; cfg_id = 2; cfg_gap = 0;
    clear_logs();
    pulse_start();
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    chk("mrst_ar_valid", {31'd0, bus.ar_valid}, 0);
    chk("mrst_r_ready", {31'd0, bus.r_ready}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_done", {31'd0, done}, 0);
    chk("mrst_beat_valid", {31'd0, beat_valid}, 0);
    chk("mrst_error", {29'd0, error_code}, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("mrst_no_done", done_cnt, 0);
    run(16'h5000, 16'hfff0, 3, 1, 4, 0, 3'b000, 2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
